// File: rtl/s27_pkg.sv
// s27_pkg
// Shared definitions for the scan-inserted s27 benchmark array.
//   - S27_STATE_W      : state flops per channel (G5, G6, G7)
//   - chain positions  : where each state flop sits in the packed {G5,G6,G7} state
//   - S27_DEFAULT_POLY : default MISR feedback taps
//   - s27_mode_e       : what a clock edge does to the state (reset/shift/hold/functional)
//   - s27_mode()       : edge priority RST > SE > HOLD > functional
//   - s27_next()       : pure s27 combinational cloud, returns {next_state, g17}
package s27_pkg;

    localparam int S27_STATE_W = 3;

    // Packed state is {G5, G6, G7}; G5 is first in the scan chain and G7 is last.
    localparam int S27_G5_POS = 2;
    localparam int S27_G6_POS = 1;
    localparam int S27_G7_POS = 0;

    localparam logic [15:0] S27_DEFAULT_POLY = 16'h100B;

    typedef enum logic [1:0] {
        MODE_RESET,
        MODE_SHIFT,
        MODE_HOLD,
        MODE_FUNC
    } s27_mode_e;

    function automatic s27_mode_e s27_mode(input logic rst, input logic se, input logic hold);
        if (rst) begin
            return MODE_RESET;
        end
        if (se) begin
            return MODE_SHIFT;
        end
        if (hold) begin
            return MODE_HOLD;
        end
        return MODE_FUNC;
    endfunction

    // Gate-for-gate copy of the s27 netlist so fault sites map back to the original.
    function automatic logic [S27_STATE_W:0] s27_next(
        input logic [S27_STATE_W-1:0] state,
        input logic                   g0,
        input logic                   g1,
        input logic                   g2,
        input logic                   g3
    );
        logic g5, g6, g7;
        logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
        g5  = state[S27_G5_POS];
        g6  = state[S27_G6_POS];
        g7  = state[S27_G7_POS];
        g14 = ~g0;
        g12 = ~(g1 | g7);
        g8  = g14 & g6;
        g15 = g12 | g8;
        g16 = g3 | g8;
        g9  = ~(g15 & g16);
        g11 = ~(g5 | g9);
        g10 = ~(g14 | g11);
        g13 = ~(g2 | g12);
        return {g10, g11, g13, ~g11};
    endfunction

endpackage

// File: rtl/s27_core.sv
// s27_core
// One s27 channel: next-state cloud plus the three state flops with a
// scan/hold/functional mux in front of them.
//   ck       : clock, rising edge
//   rst      : synchronous active-high reset, clears the state
//   se       : scan enable, state shifts G5 -> G6 -> G7 with scan_in entering G5
//   hold     : freezes the state when se is low
//   scan_in  : serial input into G5
//   g0..g3   : primary inputs
//   scan_out : G7 flop output, feeds the next channel's scan_in
//   g17c     : combinational G17 from current state and inputs
module s27_core
    import s27_pkg::*;
(
    input  logic ck,
    input  logic rst,
    input  logic se,
    input  logic hold,
    input  logic scan_in,
    input  logic g0,
    input  logic g1,
    input  logic g2,
    input  logic g3,
    output logic scan_out,
    output logic g17c
);

    logic [S27_STATE_W-1:0] state_q;
    logic [S27_STATE_W-1:0] state_d;
    logic [S27_STATE_W:0]   cloud;
    s27_mode_e              mode;

    assign cloud    = s27_next(state_q, g0, g1, g2, g3);
    assign mode     = s27_mode(rst, se, hold);
    assign scan_out = state_q[S27_G7_POS];
    assign g17c     = cloud[0];

    // Pick what the state flops load on the next edge. A shift moves every
    // flop one place toward G7, so the packed state simply slides right with
    // scan_in landing in G5.
    always_comb begin
        state_d = state_q;
        case (mode)
            MODE_RESET: state_d = '0;
            MODE_SHIFT: state_d = {scan_in, state_q[S27_G5_POS:S27_G6_POS]};
            MODE_FUNC:  state_d = cloud[S27_STATE_W:1];
            default:    state_d = state_q;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/s27_scan_array.sv
// s27_scan_array
// NCH independent s27 channels on one clock, stitched into a single scan
// chain (ch0.G5 first, ch(NCH-1).G7 last), with an optional G17 output
// register and a Galois MISR compacting the G17 port.
//   ck        : clock, rising edge
//   rst       : synchronous active-high reset
//   se        : scan enable (1 = shift)
//   si / so   : scan in (ch0.G5) / scan out (ch(NCH-1).G7)
//   hold      : freezes state, output register and MISR when se is low
//   g0..g3    : per-channel primary inputs, bit c drives channel c
//   g17       : per-channel primary output
//   misr_en   : MISR absorbs g17 on functional edges
//   misr_sig  : current MISR signature
module s27_scan_array
    import s27_pkg::*;
#(
    parameter int                NCH       = 1,
    parameter int                REG_OUT   = 0,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(S27_DEFAULT_POLY)
)(
    input  logic              ck,
    input  logic              rst,
    input  logic              se,
    input  logic              si,
    output logic              so,
    input  logic              hold,
    input  logic [NCH-1:0]    g0,
    input  logic [NCH-1:0]    g1,
    input  logic [NCH-1:0]    g2,
    input  logic [NCH-1:0]    g3,
    output logic [NCH-1:0]    g17,
    input  logic              misr_en,
    output logic [MISR_W-1:0] misr_sig
);

    // The MISR must be wide enough to absorb every channel and to have a
    // feedback bit distinct from its input bit.
    if (NCH < 1 || NCH > MISR_W || MISR_W < 2) begin : g_bad_params
        $error("s27_scan_array: need 1 <= NCH <= MISR_W and MISR_W >= 2");
    end

    logic [NCH:0]       chain;
    logic [NCH-1:0]     g17c;
    logic [MISR_W-1:0]  sig_q;
    logic [MISR_W-1:0]  sig_d;
    s27_mode_e          mode;

    assign mode     = s27_mode(rst, se, hold);
    assign chain[0] = si;
    assign so       = chain[NCH];
    assign misr_sig = sig_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        s27_core u_core (
            .ck       (ck),
            .rst      (rst),
            .se       (se),
            .hold     (hold),
            .scan_in  (chain[c]),
            .g0       (g0[c]),
            .g1       (g1[c]),
            .g2       (g2[c]),
            .g3       (g3[c]),
            .scan_out (chain[c+1]),
            .g17c     (g17c[c])
        );
    end

    if (REG_OUT != 0) begin : g_out_reg
        logic [NCH-1:0] g17_q;

        // Registered G17 only advances on functional edges; reset value is
        // all-ones so a fresh part shows a recognisable idle pattern.
        always_ff @(posedge ck) begin
            if (rst) begin
                g17_q <= '1;
            end else if (mode == MODE_FUNC) begin
                g17_q <= g17c;
            end
        end

        assign g17 = g17_q;
    end else begin : g_out_comb
        assign g17 = g17c;
    end

    // Galois MISR step: shift left, fold the outgoing MSB back through the
    // tap polynomial, then xor in whatever the g17 port shows this cycle.
    always_comb begin
        sig_d = {sig_q[MISR_W-2:0], 1'b0};
        if (sig_q[MISR_W-1]) begin
            sig_d = sig_d ^ MISR_POLY;
        end
        sig_d = sig_d ^ MISR_W'(g17);
    end

    // Signature register; it only moves on enabled functional edges.
    always_ff @(posedge ck) begin
        if (rst) begin
            sig_q <= '0;
        end else if (mode == MODE_FUNC && misr_en) begin
            sig_q <= sig_d;
        end
    end

endmodule

// File: tb/tb_s27_scan_array.sv
// tb_s27_scan_array
// Drives two s27 arrays from shared stimulus and compares them against a
// behavioural model: instance A is NCH=2 with combinational G17 and a 16-bit
// MISR, instance B is NCH=3 with registered G17 and a 4-bit MISR.
module tb_s27_scan_array;

    logic        ck;
    logic        rst;
    logic        se;
    logic        si;
    logic        hold;
    logic        misrEn;
    logic [2:0]  g0;
    logic [2:0]  g1;
    logic [2:0]  g2;
    logic [2:0]  g3;
    logic        soA;
    logic        soB;
    logic [1:0]  g17A;
    logic [2:0]  g17B;
    logic [15:0] sigA;
    logic [3:0]  sigB;

    int nChecks;
    int nPassed;

    // Model: flat scan-chain bits per instance (bit k = chain position k),
    // registered outputs and signatures as plain integers.
    bit [8:0]    chainM [2];
    bit [2:0]    outM   [2];
    int unsigned sigM   [2];

    s27_scan_array #(
        .NCH       (2),
        .REG_OUT   (0),
        .MISR_W    (16),
        .MISR_POLY (16'h100B)
    ) u_dutA (
        .ck       (ck),
        .rst      (rst),
        .se       (se),
        .si       (si),
        .so       (soA),
        .hold     (hold),
        .g0       (g0[1:0]),
        .g1       (g1[1:0]),
        .g2       (g2[1:0]),
        .g3       (g3[1:0]),
        .g17      (g17A),
        .misr_en  (misrEn),
        .misr_sig (sigA)
    );

    s27_scan_array #(
        .NCH       (3),
        .REG_OUT   (1),
        .MISR_W    (4),
        .MISR_POLY (4'h3)
    ) u_dutB (
        .ck       (ck),
        .rst      (rst),
        .se       (se),
        .si       (si),
        .so       (soB),
        .hold     (hold),
        .g0       (g0),
        .g1       (g1),
        .g2       (g2),
        .g3       (g3),
        .g17      (g17B),
        .misr_en  (misrEn),
        .misr_sig (sigB)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    function automatic int nchOf(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int widthOf(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic int unsigned polyOf(input int i);
        return (i == 0) ? 32'h100B : 32'h3;
    endfunction

    // s27 behaviour reduced to sum-of-products form; returns {G5',G6',G7',G17}.
    function automatic bit [3:0] refChannel(input bit s5, input bit s6, input bit s7,
                                            input bit a0, input bit a1, input bit a2, input bit a3);
        bit t8, t12, t11;
        t8  = !a0 && s6;
        t12 = !a1 && !s7;
        t11 = !s5 && (t8 || (t12 && a3));
        return {a0 && !t11, t11, !a2 && (a1 || s7), !t11};
    endfunction

    function automatic bit [3:0] channelOf(input int i, input int c);
        return refChannel(chainM[i][3*c], chainM[i][3*c+1], chainM[i][3*c+2],
                          g0[c], g1[c], g2[c], g3[c]);
    endfunction

    function automatic bit [2:0] modelComb(input int i);
        bit [2:0] r;
        bit [3:0] n;
        r = '0;
        for (int c = 0; c < nchOf(i); c++) begin
            n    = channelOf(i, c);
            r[c] = n[0];
        end
        return r;
    endfunction

    function automatic bit [2:0] modelPort(input int i);
        return (i == 0) ? modelComb(0) : outM[1];
    endfunction

    function automatic bit modelSo(input int i);
        return chainM[i][3*nchOf(i)-1];
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic modelEdge();
        for (int i = 0; i < 2; i++) begin
            int          n;
            int unsigned mask;
            bit [2:0]    port;
            bit [2:0]    comb;
            bit [8:0]    nxt;
            bit [3:0]    r;
            n    = nchOf(i);
            mask = (32'd1 << widthOf(i)) - 1;
            if (rst) begin
                chainM[i] = '0;
                outM[i]   = 3'b111;
                sigM[i]   = 0;
            end else if (se) begin
                chainM[i] = {chainM[i][7:0], si} & 9'((32'd1 << (3*n)) - 1);
            end else if (!hold) begin
                port = modelPort(i);
                comb = modelComb(i);
                if (misrEn) begin
                    int unsigned s;
                    s = sigM[i] << 1;
                    if (((sigM[i] >> (widthOf(i) - 1)) & 1) != 0) begin
                        s = s ^ polyOf(i);
                    end
                    sigM[i] = (s ^ 32'(port)) & mask;
                end
                nxt = '0;
                for (int c = 0; c < n; c++) begin
                    r          = channelOf(i, c);
                    nxt[3*c]   = r[3];
                    nxt[3*c+1] = r[2];
                    nxt[3*c+2] = r[1];
                end
                chainM[i] = nxt;
                outM[i]   = comb;
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        nChecks++;
        if (observed === expected) begin
            nPassed++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput($sformatf("%s/soA", tag),  16'(soA),  16'(modelSo(0)));
        checkOutput($sformatf("%s/soB", tag),  16'(soB),  16'(modelSo(1)));
        checkOutput($sformatf("%s/g17A", tag), 16'(g17A), 16'(modelPort(0) & 3'b011));
        checkOutput($sformatf("%s/g17B", tag), 16'(g17B), 16'(modelPort(1)));
        checkOutput($sformatf("%s/sigA", tag), sigA,      16'(sigM[0]));
        checkOutput($sformatf("%s/sigB", tag), 16'(sigB), 16'(sigM[1]));
    endtask

    // Drive one cycle of inputs, clock it, step the model, then compare just
    // after the edge.
    task automatic applyStimulus(input string tag, input bit r, input bit s, input bit sIn,
                                 input bit h, input bit m, input bit [2:0] a0, input bit [2:0] a1,
                                 input bit [2:0] a2, input bit [2:0] a3);
        rst    = r;
        se     = s;
        si     = sIn;
        hold   = h;
        misrEn = m;
        g0     = a0;
        g1     = a1;
        g2     = a2;
        g3     = a3;
        @(posedge ck);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    task automatic randomCycle(input string tag, input bit s, input bit h);
        applyStimulus(tag, 1'b0, s, 1'($urandom), h, 1'($urandom_range(0, 3) != 0),
                      3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
    endtask

    initial begin
        int       expSig [3];
        bit [5:0] pat;
        expSig  = '{1, 3, 7};
        pat     = 6'b001101;
        nChecks = 0;
        nPassed = 0;

        // Reset: everything zero, registered G17 all-ones.
        applyStimulus("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000);
        checkOutput("reset soA", 16'(soA), 16'd0);
        checkOutput("reset sigA", sigA, 16'd0);
        checkOutput("reset g17B", 16'(g17B), 16'h7);

        // ch0 sees G0..G3=0,1,0,0 (state 000->001, G17=1), ch1 sees 1,0,0,1
        // (state 000->010, G17=0), so the signature runs 1, 3, 7.
        for (int k = 0; k < 3; k++) begin
            applyStimulus("misr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3'b001, 3'b000, 3'b010);
            checkOutput($sformatf("misr sig edge%0d", k + 1), sigA, 16'(expSig[k]));
            checkOutput($sformatf("misr g17 edge%0d", k + 1), 16'(g17A), 16'h1);
        end

        // Shift 1,0,1,1,0,0 through the 6-bit chain of instance A with noisy inputs.
        for (int k = 0; k < 6; k++) begin
            applyStimulus("shift in", 1'b0, 1'b1, pat[k], 1'($urandom), 1'($urandom),
                          3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        end
        checkOutput("shift so first", 16'(soA), 16'd1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus("shift out", 1'b0, 1'b1, 1'b0, 1'($urandom), 1'b1,
                          3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            checkOutput($sformatf("shift so bit%0d", k + 1), 16'(soA), 16'(pat[k+1]));
        end
        checkOutput("shift sig held", sigA, 16'd7);

        // Functional activity, then hold for five cycles, then release.
        for (int k = 0; k < 6; k++) randomCycle("func", 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) randomCycle("hold", 1'b0, 1'b1);
        for (int k = 0; k < 6; k++) randomCycle("release", 1'b0, 1'b0);

        // Reset arriving after three of six shift bits.
        for (int k = 0; k < 3; k++) begin
            applyStimulus("pre midrst", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                          3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        end
        applyStimulus("midrst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b111, 3'b111, 3'b111, 3'b111);
        checkOutput("midrst soA", 16'(soA), 16'd0);
        checkOutput("midrst soB", 16'(soB), 16'd0);
        checkOutput("midrst sigA", sigA, 16'd0);
        checkOutput("midrst sigB", 16'(sigB), 16'd0);
        checkOutput("midrst g17B", 16'(g17B), 16'h7);

        // Random mix of every mode.
        for (int k = 0; k < 400; k++) begin
            applyStimulus("random", 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 5) == 0),
                          1'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) != 0),
                          3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
        end

        $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
